axis_mux_rr_sched: RTL and testbench

- Round-robin frame scheduler that drives the enable/select control inputs of the S_COUNT-input AXI-Stream frame multiplexer directly downstream of it.
- Passively taps each input port's tvalid/tready/tlast (the mux's s_axis_* bus) and grants one whole frame at a time.
- Advances fairly among requesting ports; never changes select mid-frame.
- Provides a per-port software request mask.

---
 rtl/axis_mux_rr_sched.sv | 156 +++++++++++++++
 tb/tb_axis_mux_rr_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_mux_rr_sched.sv
// Round-robin whole-frame scheduler driving the enable/select of a downstream AXI-Stream mux.
// Optional per-port completed-frame counters are built when AXIS_MUX_RR_SCHED_STATS_EN is defined.
module axis_mux_rr_sched #(
  parameter int S_COUNT   = 4,
  parameter int CNT_WIDTH = 16,
  localparam int SEL_W    = $clog2(S_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [S_COUNT-1:0]           s_axis_tvalid,
  input  logic [S_COUNT-1:0]           s_axis_tready,
  input  logic [S_COUNT-1:0]           s_axis_tlast,
  input  logic [S_COUNT-1:0]           port_mask,
  output logic                         enable,
  output logic [SEL_W-1:0]             select,
  output logic                         busy
`ifdef AXIS_MUX_RR_SCHED_STATS_EN
  ,
  output logic [S_COUNT*CNT_WIDTH-1:0] frame_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic [SEL_W-1:0]   last_q, last_d;

  logic [S_COUNT-1:0] req;
  logic [SEL_W-1:0]   winner;
  logic [SEL_W-1:0]   cand;
  logic               found;
  logic               hs;
  logic               hs_last;

  assign req     = s_axis_tvalid & port_mask;
  assign hs      = s_axis_tvalid[select_q] & s_axis_tready[select_q];
  assign hs_last = hs & s_axis_tlast[select_q];

  // Scan last+1, last+2, ... so the port just served is considered last.
  always_comb begin
    winner = last_q;
    cand   = last_q;
    found  = 1'b0;
    for (int i = 1; i <= S_COUNT; i++) begin
      cand = SEL_W'((int'(last_q) + i) % S_COUNT);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    select_d = select_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        busy_d   = 1'b0;
        if (|req) begin
          select_d = winner;
          last_d   = winner;
          enable_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        enable_d = 1'b1;
        busy_d   = 1'b1;
        if (hs) begin
          enable_d = 1'b0;
          if (s_axis_tlast[select_q]) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        enable_d = 1'b0;
        busy_d   = 1'b1;
        if (hs_last) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        enable_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      select_q <= '0;
      last_q   <= SEL_W'(S_COUNT - 1);
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      select_q <= select_d;
      last_q   <= last_d;
    end
  end

  assign enable = enable_q;
  assign select = select_q;
  assign busy   = busy_q;

`ifdef AXIS_MUX_RR_SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [S_COUNT];
  logic [CNT_WIDTH-1:0] cnt_d [S_COUNT];

  // Counters wrap naturally at 2^CNT_WIDTH.
  always_comb begin
    for (int p = 0; p < S_COUNT; p++) begin
      cnt_d[p] = cnt_q[p];
      if ((state_q != IDLE) && hs_last && (select_q == SEL_W'(p))) begin
        cnt_d[p] = cnt_q[p] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < S_COUNT; p++) begin
      if (rst) begin
        cnt_q[p] <= '0;
      end else begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  for (genvar g = 0; g < S_COUNT; g++) begin : g_fc
    assign frame_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_axis_mux_rr_sched.sv
// Bench for axis_mux_rr_sched: frame sources plus a behavioural downstream mux around the scheduler.
module tb_axis_mux_rr_sched;
  localparam int S = 4;
`ifdef AXIS_MUX_RR_SCHED_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [S-1:0] s_axis_tvalid;
  logic [S-1:0] s_axis_tready;
  logic [S-1:0] s_axis_tlast;
  logic [S-1:0] port_mask;
  logic         enable;
  logic [1:0]   select;
  logic         busy;
`ifdef AXIS_MUX_RR_SCHED_STATS_EN
  logic [S*CW-1:0] frame_count;
`endif

  axis_mux_rr_sched #(.S_COUNT(S), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .port_mask     (port_mask),
    .enable        (enable),
    .select        (select),
    .busy          (busy)
`ifdef AXIS_MUX_RR_SCHED_STATS_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst_first;
    logic [S-1:0][2:0] nfr;
    logic [2:0]       len;
    logic [3:0]       mask;
    logic [2:0]       ngr;
    logic [4:0][1:0]  exp;
    logic             gap;
    logic             noact;
  } vec_t;

  int         frames [S];
  int         beat   [S];
  int         flen   [S];
  bit         mux_act;
  logic [1:0] mux_sel;
  int         exp_q [$];
  int         n_chk, n_pass, cyc;
  bit         prev_busy, prev_beat, prev_last;
  logic [1:0] prev_sel;
  int         last_end, load_cyc;
  bit         gap_chk, active_seen, first_grant;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic vec_t mk(bit r, int n0, int n1, int n2, int n3, int len, logic [3:0] m,
                              int ng, int e0, int e1, int e2, int e3, int e4, bit g, bit na);
    vec_t v;
    v.rst_first = r;
    v.nfr[0] = 3'(n0); v.nfr[1] = 3'(n1); v.nfr[2] = 3'(n2); v.nfr[3] = 3'(n3);
    v.len  = 3'(len);
    v.mask = m;
    v.ngr  = 3'(ng);
    v.exp[0] = 2'(e0); v.exp[1] = 2'(e1); v.exp[2] = 2'(e2); v.exp[3] = 2'(e3); v.exp[4] = 2'(e4);
    v.gap   = g;
    v.noact = na;
    return v;
  endfunction

  function automatic void drive();
    for (int p = 0; p < S; p++) begin
      s_axis_tvalid[p] = (frames[p] > 0);
      s_axis_tlast[p]  = (frames[p] > 0) && (beat[p] == flen[p] - 1);
    end
    s_axis_tready = mux_act ? (4'b0001 << mux_sel) : 4'b0000;
  endfunction

  // One clock: monitor at the falling edge, advance the models just after the rising edge.
  task automatic tick();
    logic [S-1:0] hs;
    bit           en_s, b_s, r_s;
    logic [1:0]   sel_s;
    @(negedge clk);
    cyc++;
    en_s = enable; b_s = busy; sel_s = select; r_s = rst;
    hs = s_axis_tvalid & s_axis_tready;
    if (!r_s) begin
      if (b_s && !prev_busy) begin
        check("grant_enable", int'(en_s), 1);
        if (exp_q.size() == 0) check("unexpected_grant", int'(sel_s), -1);
        else check("grant_port", int'(sel_s), exp_q.pop_front());
        if (first_grant) begin
          check("grant_latency", cyc - load_cyc, 1);
          first_grant = 1'b0;
        end else if (gap_chk && last_end >= 0) begin
          check("grant_gap", cyc - last_end, 2);
        end
      end
      if (prev_busy && b_s) check("select_held", int'(sel_s), int'(prev_sel));
      if (prev_beat) check("enable_low_after_beat", int'(en_s), 0);
      if (prev_last) check("busy_low_after_last", int'(b_s), 0);
      if (b_s && !en_s) active_seen = 1'b1;
      prev_beat = b_s && hs[sel_s];
      prev_last = prev_beat && s_axis_tlast[sel_s];
      if (prev_last) last_end = cyc;
      prev_busy = b_s;
      prev_sel  = sel_s;
    end else begin
      prev_beat = 1'b0; prev_last = 1'b0; prev_busy = 1'b0; prev_sel = '0;
    end
    @(posedge clk);
    #1;
    if (r_s) begin
      mux_act = 1'b0;
      mux_sel = '0;
      exp_q.delete();
      for (int p = 0; p < S; p++) begin
        frames[p] = 0;
        beat[p]   = 0;
      end
    end else begin
      if (mux_act && hs[mux_sel] && s_axis_tlast[mux_sel]) mux_act = 1'b0;
      else if (!mux_act && en_s) begin
        mux_act = 1'b1;
        mux_sel = sel_s;
      end
      for (int p = 0; p < S; p++) begin
        if (hs[p]) begin
          beat[p]++;
          if (beat[p] == flen[p]) begin
            beat[p] = 0;
            frames[p]--;
          end
        end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_enable", int'(enable), 0);
    check("rst_select", int'(select), 0);
    check("rst_busy", int'(busy), 0);
  endtask

  task automatic arm(input bit g);
    gap_chk     = g;
    last_end    = -1;
    active_seen = 1'b0;
    first_grant = 1'b1;
    load_cyc    = cyc + 1;
    drive();
  endtask

  task automatic run_done();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      tick();
      k++;
    end
    check("grants_outstanding", exp_q.size(), 0);
    check("idle_after_frames", int'(busy), 0);
    repeat (6) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   k;
    n_chk = 0; n_pass = 0; cyc = 0;
    mux_act = 1'b0; mux_sel = '0;
    prev_busy = 1'b0; prev_beat = 1'b0; prev_last = 1'b0; prev_sel = '0;
    for (int p = 0; p < S; p++) begin
      frames[p] = 0; beat[p] = 0; flen[p] = 1;
    end
    rst = 1'b1;
    port_mask = 4'hF;
    drive();

    //            rst n0 n1 n2 n3 len mask     ng  expected grants  gap noact
    vecs[0] = mk(1, 0, 0, 1, 0, 3, 4'hF,    1,  2, 0, 0, 0, 0,  0, 0);
    vecs[1] = mk(0, 1, 1, 1, 1, 1, 4'hF,    4,  3, 0, 1, 2, 0,  1, 1);
    vecs[2] = mk(1, 2, 1, 1, 1, 2, 4'hF,    5,  0, 1, 2, 3, 0,  1, 0);
    vecs[3] = mk(0, 0, 2, 0, 1, 1, 4'hF,    3,  1, 3, 1, 0, 0,  1, 1);
    vecs[4] = mk(0, 0, 0, 1, 1, 2, 4'b1011, 1,  3, 0, 0, 0, 0,  0, 0);
    vecs[5] = mk(0, 0, 0, 0, 0, 2, 4'hF,    1,  2, 0, 0, 0, 0,  0, 0);

    do_reset();
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].rst_first) do_reset();
      port_mask = vecs[v].mask;
      for (int p = 0; p < S; p++) begin
        if (vecs[v].nfr[p] != 0) begin
          frames[p] += int'(vecs[v].nfr[p]);
          flen[p]    = int'(vecs[v].len);
        end
      end
      for (int i = 0; i < int'(vecs[v].ngr); i++) exp_q.push_back(int'(vecs[v].exp[i]));
      arm(vecs[v].gap);
      run_done();
      if (vecs[v].noact) check("active_not_entered", int'(active_seen), 0);
    end

    // Reset in the middle of a 4-beat frame on port 0.
    do_reset();
    port_mask = 4'hF;
    frames[0] = 1; flen[0] = 4;
    exp_q.push_back(0);
    arm(1'b0);
    k = 0;
    while (beat[0] < 1 && k < 50) begin
      tick();
      k++;
    end
    check("reached_beat2", beat[0], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_enable", int'(enable), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_select", int'(select), 0);
    frames[0] = 1; flen[0] = 2;
    frames[1] = 1; flen[1] = 2;
    exp_q.push_back(0);
    exp_q.push_back(1);
    arm(1'b0);
    run_done();

`ifdef AXIS_MUX_RR_SCHED_STATS_EN
    do_reset();
    port_mask = 4'hF;
    for (int f = 0; f < 5; f++) begin
      frames[1] = 1; flen[1] = 2;
      exp_q.push_back(1);
      arm(1'b0);
      run_done();
      check("frame_count_p1", int'(frame_count[CW +: CW]), (f + 1) % 4);
      check("frame_count_others",
            int'({frame_count[0 +: CW], frame_count[2*CW +: CW], frame_count[3*CW +: CW]}), 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
